// File: rtl/ysyx_23060187_pc_gen.sv
`default_nettype none
// ============================================================================
// Module  : ysyx_23060187_pc_gen
// Purpose : NPC fetch-stage program counter with valid/ready issue, redirects
//           (jal/jalr/branch/trap/mret), epoch tagging and misalign reporting.
// Revision: 1.0 - initial release
// ============================================================================
module ysyx_23060187_pc_gen #(
  parameter int              XLEN       = 32,
  parameter logic [XLEN-1:0] RESET_VEC  = XLEN'(32'h8000_0000),
  parameter int              STEP       = 4,
  parameter int              BOOT_DELAY = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            redir_valid_i,
  input  logic [2:0]      redir_kind_i,
  input  logic [XLEN-1:0] redir_pc_i,
  input  logic [XLEN-1:0] imm_i,
  input  logic [XLEN-1:0] src1_i,
  input  logic            br_taken_i,
  input  logic [XLEN-1:0] mtvec_i,
  input  logic [XLEN-1:0] mepc_i,
  input  logic            pc_ready_i,
  output logic            pc_valid_o,
  output logic [XLEN-1:0] pc_out_o,
  output logic            pc_epoch_o,
  output logic            pc_stale_o,
  output logic            misalign_o,
  output logic [XLEN-1:0] misalign_addr_o
);

  localparam int              CNT_W  = $clog2(BOOT_DELAY + 1);
  localparam logic [CNT_W-1:0] CNT_RST = CNT_W'(BOOT_DELAY);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [XLEN-1:0] STEP_W = XLEN'(STEP);
  localparam logic [XLEN-1:0] LSB_W  = XLEN'(1);

  localparam logic [2:0] K_JAL    = 3'd0;
  localparam logic [2:0] K_JALR   = 3'd1;
  localparam logic [2:0] K_BRANCH = 3'd2;
  localparam logic [2:0] K_TRAP   = 3'd3;
  localparam logic [2:0] K_MRET   = 3'd4;

  typedef enum logic [1:0] {
    S_BOOT = 2'd0,
    S_RUN  = 2'd1,
    S_PEND = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] boot_cnt_q, boot_cnt_d;
  logic [XLEN-1:0]  pc_q, pc_d;
  logic [XLEN-1:0]  pend_pc_q, pend_pc_d;
  logic             epoch_q, epoch_d;
  logic             misalign_q, misalign_d;
  logic [XLEN-1:0]  misalign_addr_q, misalign_addr_d;

  logic [XLEN-1:0]  target;
  logic             redir_eff;
  logic             aligned;
  logic             redir_ok;
  logic             redir_bad;
  logic             valid;
  logic             fire;
  logic             stall;

  always_comb begin
    target = '0;
    case (redir_kind_i)
      K_JAL, K_BRANCH: target = redir_pc_i + imm_i;
      K_JALR:          target = (src1_i + imm_i) & ~LSB_W;
      K_TRAP:          target = mtvec_i;
      K_MRET:          target = mepc_i;
      default:         target = '0;
    endcase
  end

  assign redir_eff = redir_valid_i && (redir_kind_i <= K_MRET) &&
                     ((redir_kind_i != K_BRANCH) || br_taken_i);
  assign aligned   = ((target % STEP_W) == '0);
  // Redirects are only honoured once the fetch stream is running.
  assign redir_ok  = redir_eff && aligned && (state_q != S_BOOT);
  assign redir_bad = redir_eff && !aligned && (state_q != S_BOOT);

  assign valid = (state_q != S_BOOT);
  assign fire  = valid && pc_ready_i;
  assign stall = valid && !pc_ready_i;

  always_comb begin
    state_d         = state_q;
    boot_cnt_d      = boot_cnt_q;
    pc_d            = pc_q;
    pend_pc_d       = pend_pc_q;
    epoch_d         = epoch_q;
    misalign_d      = 1'b0;
    misalign_addr_d = misalign_addr_q;

    if (redir_bad) begin
      misalign_d      = 1'b1;
      misalign_addr_d = target;
    end

    case (state_q)
      S_BOOT: begin
        boot_cnt_d = boot_cnt_q - CNT_ONE;
        if (boot_cnt_q <= CNT_ONE) begin
          boot_cnt_d = '0;
          state_d    = S_RUN;
        end
      end

      S_RUN: begin
        if (redir_ok) begin
          if (stall) begin
            // Held request must stay stable; park the target until accepted.
            pend_pc_d = target;
            state_d   = S_PEND;
          end else begin
            pc_d    = target;
            epoch_d = ~epoch_q;
          end
        end else if (fire) begin
          pc_d = pc_q + STEP_W;
        end
      end

      S_PEND: begin
        if (redir_ok) begin
          pend_pc_d = target;
        end
        if (fire) begin
          pc_d    = redir_ok ? target : pend_pc_q;
          epoch_d = ~epoch_q;
          state_d = S_RUN;
        end
      end

      default: begin
        state_d = S_BOOT;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= S_BOOT;
      boot_cnt_q      <= CNT_RST;
      pc_q            <= RESET_VEC;
      pend_pc_q       <= '0;
      epoch_q         <= 1'b0;
      misalign_q      <= 1'b0;
      misalign_addr_q <= '0;
    end else begin
      state_q         <= state_d;
      boot_cnt_q      <= boot_cnt_d;
      pc_q            <= pc_d;
      pend_pc_q       <= pend_pc_d;
      epoch_q         <= epoch_d;
      misalign_q      <= misalign_d;
      misalign_addr_q <= misalign_addr_d;
    end
  end

  assign pc_valid_o      = valid;
  assign pc_out_o        = pc_q;
  assign pc_epoch_o      = epoch_q;
  assign pc_stale_o      = (state_q == S_PEND);
  assign misalign_o      = misalign_q;
  assign misalign_addr_o = misalign_addr_q;

endmodule
`default_nettype wire

// File: tb/tb_ysyx_23060187_pc_gen.sv
`default_nettype none
// ============================================================================
// Module  : tb_ysyx_23060187_pc_gen
// Purpose : Directed vector bench for the fetch-stage PC generator.
// Revision: 1.0 - initial release
// ============================================================================
module tb_ysyx_23060187_pc_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic        redir_valid_i;
  logic [2:0]  redir_kind_i;
  logic [31:0] redir_pc_i, imm_i, src1_i, mtvec_i, mepc_i;
  logic        br_taken_i, pc_ready_i;
  logic        pc_valid_o, pc_epoch_o, pc_stale_o, misalign_o;
  logic [31:0] pc_out_o, misalign_addr_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ysyx_23060187_pc_gen dut (
    .clk             (clk),
    .rst             (rst),
    .redir_valid_i   (redir_valid_i),
    .redir_kind_i    (redir_kind_i),
    .redir_pc_i      (redir_pc_i),
    .imm_i           (imm_i),
    .src1_i          (src1_i),
    .br_taken_i      (br_taken_i),
    .mtvec_i         (mtvec_i),
    .mepc_i          (mepc_i),
    .pc_ready_i      (pc_ready_i),
    .pc_valid_o      (pc_valid_o),
    .pc_out_o        (pc_out_o),
    .pc_epoch_o      (pc_epoch_o),
    .pc_stale_o      (pc_stale_o),
    .misalign_o      (misalign_o),
    .misalign_addr_o (misalign_addr_o)
  );

  typedef struct {
    logic        rst;
    logic        rv;
    logic [2:0]  kind;
    logic [31:0] rpc;
    logic [31:0] imm;
    logic [31:0] op;
    logic        bt;
    logic        rdy;
    logic        e_valid;
    logic [31:0] e_pc;
    logic        e_ep;
    logic        e_st;
    logic        e_mis;
    logic [31:0] e_maddr;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic r, logic rv, logic [2:0] k, logic [31:0] rpc,
                              logic [31:0] imm, logic [31:0] op, logic bt, logic rdy,
                              logic ev, logic [31:0] epc, logic eep, logic est,
                              logic emis, logic [31:0] emaddr);
    vec_t v;
    v.rst = r; v.rv = rv; v.kind = k; v.rpc = rpc; v.imm = imm; v.op = op;
    v.bt = bt; v.rdy = rdy; v.e_valid = ev; v.e_pc = epc; v.e_ep = eep;
    v.e_st = est; v.e_mis = emis; v.e_maddr = emaddr;
    return v;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // op drives src1, mtvec and mepc together; only the selected kind uses it.
  task automatic drive(logic r, logic rv, logic [2:0] k, logic [31:0] rpc,
                       logic [31:0] imm, logic [31:0] op, logic bt, logic rdy);
    @(negedge clk);
    rst = r; redir_valid_i = rv; redir_kind_i = k; redir_pc_i = rpc; imm_i = imm;
    src1_i = op; mtvec_i = op; mepc_i = op; br_taken_i = bt; pc_ready_i = rdy;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n;
    rst = 1'b1; redir_valid_i = 1'b0; redir_kind_i = 3'd0; redir_pc_i = '0;
    imm_i = '0; src1_i = '0; mtvec_i = '0; mepc_i = '0; br_taken_i = 1'b0;
    pc_ready_i = 1'b1;

    // T1 reset / boot
    tbl.push_back(mk(1,0,0,0,0,0,0,1, 0,32'h80000000,0,0,0,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,1, 0,32'h80000000,0,0,0,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,1, 1,32'h80000000,0,0,0,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,1, 1,32'h80000004,0,0,0,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,1, 1,32'h80000008,0,0,0,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,1, 1,32'h8000000C,0,0,0,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,1, 1,32'h80000010,0,0,0,0));
    // T2 jal wins over the simultaneous fire
    tbl.push_back(mk(0,1,0,32'h8000000C,32'h20,0,0,1, 1,32'h8000002C,1,0,0,0));
    // T3 stalled jalr -> PEND, then released
    tbl.push_back(mk(0,1,1,0,0,32'h80001001,0,0, 1,32'h8000002C,1,1,0,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,0, 1,32'h8000002C,1,1,0,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,1, 1,32'h80001000,0,0,0,0));
    // T4 not-taken branch and ignored kind 5, then trap and taken branch
    tbl.push_back(mk(0,1,2,32'h80001000,32'h100,0,0,1, 1,32'h80001004,0,0,0,0));
    tbl.push_back(mk(0,1,5,0,0,0,0,1, 1,32'h80001008,0,0,0,0));
    tbl.push_back(mk(0,1,3,0,0,32'h80000020,0,1, 1,32'h80000020,1,0,0,0));
    tbl.push_back(mk(0,1,2,32'h80000020,32'hFFFFFFF8,0,1,1, 1,32'h80000018,0,0,0,0));
    // T5 misaligned jal dropped, pulse lasts one cycle
    tbl.push_back(mk(0,1,0,32'h80000000,32'h2,0,0,0, 1,32'h80000018,0,0,1,32'h80000002));
    tbl.push_back(mk(0,0,0,0,0,0,0,0, 1,32'h80000018,0,0,0,0));
    // T6 wrap, then PEND with latest-wins redirect, then reset
    tbl.push_back(mk(0,1,4,0,0,32'hFFFFFFFC,0,1, 1,32'hFFFFFFFC,1,0,0,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,1, 1,32'h00000000,1,0,0,0));
    tbl.push_back(mk(0,1,3,0,0,32'h80000100,0,0, 1,32'h00000000,1,1,0,0));
    tbl.push_back(mk(0,1,0,32'h80000200,32'h4,0,0,0, 1,32'h00000000,1,1,0,0));
    tbl.push_back(mk(1,0,0,0,0,0,0,0, 0,32'h80000000,0,0,0,0));
    // Redirect during BOOT is ignored; the pending target never appears
    tbl.push_back(mk(0,1,0,32'h80000400,32'h0,0,0,1, 0,32'h80000000,0,0,0,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,1, 1,32'h80000000,0,0,0,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,1, 1,32'h80000004,0,0,0,0));

    foreach (tbl[i]) begin
      drive(tbl[i].rst, tbl[i].rv, tbl[i].kind, tbl[i].rpc, tbl[i].imm,
            tbl[i].op, tbl[i].bt, tbl[i].rdy);
      chk($sformatf("v%0d_valid", i), {31'd0, pc_valid_o}, {31'd0, tbl[i].e_valid});
      chk($sformatf("v%0d_pc", i), pc_out_o, tbl[i].e_pc);
      chk($sformatf("v%0d_epoch", i), {31'd0, pc_epoch_o}, {31'd0, tbl[i].e_ep});
      chk($sformatf("v%0d_stale", i), {31'd0, pc_stale_o}, {31'd0, tbl[i].e_st});
      chk($sformatf("v%0d_misalign", i), {31'd0, misalign_o}, {31'd0, tbl[i].e_mis});
      if (tbl[i].e_mis)
        chk($sformatf("v%0d_maddr", i), misalign_addr_o, tbl[i].e_maddr);
    end

    // PEND with a redirect arriving on the releasing fire: new target wins
    drive(0,1,0,32'h80000000,32'h40,0,0,0);
    chk("pend_enter_stale", {31'd0, pc_stale_o}, 32'd1);
    chk("pend_enter_pc", pc_out_o, 32'h80000004);
    drive(0,1,1,0,32'h4,32'h80003000,0,1);
    chk("pend_fire_pc", pc_out_o, 32'h80003004);
    chk("pend_fire_epoch", {31'd0, pc_epoch_o}, 32'd1);
    chk("pend_fire_stale", {31'd0, pc_stale_o}, 32'd0);
    drive(0,0,0,0,0,0,0,1);
    chk("post_pend_seq", pc_out_o, 32'h80003008);

    // Boot latency measured with a bounded wait
    drive(1,0,0,0,0,0,0,1);
    n = 0;
    rst = 1'b0;
    while (!pc_valid_o && n < 10) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("boot_latency", n, 2);
    chk("boot_first_pc", pc_out_o, 32'h80000000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
